// File: rtl/gps_srq_sched_pkg.sv
// Shared constants for the GPS service-request scheduler.
// Channel count and index width, CPU opcode bit positions, FSM encoding.
// No logic; imported by the scheduler and its round-robin finder.
package gps_srq_sched_pkg;

  localparam int GPS_CHANS   = 12;
  localparam int CHAN_BITS   = 4;
  localparam int OVR_BITS    = 4;
  localparam int HOST_MAX    = 8;
  localparam int ACK_TIMEOUT = 65535;
  localparam int TMR_BITS    = 16;

  // Bit positions of the CPU event opcodes that drive svc_ack / ovr_clr
  localparam int SVC_ACK_BIT = 0;
  localparam int OVR_CLR_BIT = 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARB   = 2'd1;
  localparam logic [1:0] ST_GRANT = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    ARB   = ST_ARB,
    GRANT = ST_GRANT
  } state_t;

endpackage

// File: rtl/gps_rr_pick.sv
// Round-robin priority finder: first set request at or after ptr+1, wrapping.
// Purely combinational, zero latency.
// No flow control; found=0 when the request vector is empty.
module gps_rr_pick #(
  parameter int N = 12,
  parameter int W = 4
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] idx
);

  // Scan N slots upward from ptr+1 and keep the first hit
  always_comb begin
    int c;
    found = 1'b0;
    idx   = '0;
    c     = 0;
    for (int k = 1; k <= N; k++) begin
      c = int'(ptr) + k;
      if (c >= N) c = c - N;
      if (c >= N) c = c - N;
      if (!found && req[c[W-1:0]]) begin
        found = 1'b1;
        idx   = W'(c);
      end
    end
  end

endmodule

// File: rtl/gps_srq_sched.sv
// Latches channel epoch pulses and grants them (plus host) round-robin to the CPU.
// Pulse to pending: 1 cycle; pulse to svc_valid: 3 cycles; ack drops valid next cycle.
// One grant outstanding; held until svc_ack, channel mask-off, or ack timeout.
module gps_srq_sched
  import gps_srq_sched_pkg::*;
#(
  parameter int ACK_TIMEOUT_CYC = ACK_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [GPS_CHANS-1:0] chan_srq,
  input  logic                 host_srq,
  input  logic [GPS_CHANS-1:0] chan_mask,
  input  logic                 svc_ack,
  output logic                 svc_valid,
  output logic                 svc_host,
  output logic [CHAN_BITS-1:0] svc_chan,
  output logic [GPS_CHANS-1:0] pending,
  output logic                 timeout_flag,
  input  logic [CHAN_BITS-1:0] ovr_sel,
  output logic [OVR_BITS-1:0]  ovr_cnt,
  input  logic                 ovr_clr
);

  localparam int SB = $clog2(HOST_MAX + 1);

  state_t               state;
  logic [CHAN_BITS-1:0] rr;
  logic [SB-1:0]        starve;
  logic [TMR_BITS-1:0]  tmr;
  logic [OVR_BITS-1:0]  ovr [GPS_CHANS];

  logic [GPS_CHANS-1:0] req;
  logic [GPS_CHANS-1:0] grant_vec;
  logic [GPS_CHANS-1:0] ack_vec;
  logic                 chan_drop;
  logic                 tmo;
  logic                 found;
  logic [CHAN_BITS-1:0] pick;
  logic                 host_pick;

  // Only enabled channels compete in arbitration
  assign req = pending & chan_mask;

  // One-hot of the channel currently granted (empty for host grants / no grant)
  always_comb begin
    grant_vec = '0;
    for (int i = 0; i < GPS_CHANS; i++)
      grant_vec[i] = (state == GRANT) && !svc_host && (svc_chan == CHAN_BITS'(i));
  end

  assign ack_vec   = grant_vec & {GPS_CHANS{svc_ack}};
  assign chan_drop = |(grant_vec & ~chan_mask);
  assign tmo       = (state == GRANT) && !svc_ack && !chan_drop &&
                     (tmr == TMR_BITS'(ACK_TIMEOUT_CYC - 1));
  assign host_pick = host_srq && (!(|req) || (starve >= SB'(HOST_MAX)));

  gps_rr_pick #(.N(GPS_CHANS), .W(CHAN_BITS)) u_pick (
    .req   (req),
    .ptr   (rr),
    .found (found),
    .idx   (pick)
  );

  // Pending epoch bits and saturating overrun counters per channel
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      for (int i = 0; i < GPS_CHANS; i++) ovr[i] <= '0;
    end else begin
      for (int i = 0; i < GPS_CHANS; i++) begin
        if (!chan_mask[i])    pending[i] <= 1'b0;
        else if (chan_srq[i]) pending[i] <= 1'b1;
        else if (ack_vec[i])  pending[i] <= 1'b0;

        if (ovr_clr)
          ovr[i] <= '0;
        else if (chan_srq[i] && chan_mask[i] && pending[i] && !ack_vec[i] && (ovr[i] != '1))
          ovr[i] <= ovr[i] + 1'b1;
      end
    end
  end

  // Overrun readback; unused selector codes read as zero
  always_comb begin
    ovr_cnt = '0;
    for (int i = 0; i < GPS_CHANS; i++)
      if (ovr_sel == CHAN_BITS'(i)) ovr_cnt = ovr[i];
  end

  // Grant FSM with registered grant outputs, rr pointer, starve and timeout tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      rr           <= CHAN_BITS'(GPS_CHANS - 1);
      starve       <= '0;
      tmr          <= '0;
      svc_valid    <= 1'b0;
      svc_host     <= 1'b0;
      svc_chan     <= '0;
      timeout_flag <= 1'b0;
    end else begin
      if (ovr_clr)  timeout_flag <= 1'b0;
      else if (tmo) timeout_flag <= 1'b1;

      case (state)
        IDLE: begin
          if ((|pending) || host_srq) state <= ARB;
        end
        ARB: begin
          tmr <= '0;
          if (host_pick) begin
            svc_valid <= 1'b1;
            svc_host  <= 1'b1;
            svc_chan  <= '0;
            state     <= GRANT;
          end else if (found) begin
            svc_valid <= 1'b1;
            svc_host  <= 1'b0;
            svc_chan  <= pick;
            state     <= GRANT;
          end else begin
            state <= IDLE;
          end
        end
        GRANT: begin
          if (svc_ack || chan_drop || tmo) begin
            if (svc_ack && svc_host) begin
              starve <= '0;
            end else if (!svc_host) begin
              rr <= svc_chan;
              if (svc_ack && host_srq && (starve != '1)) starve <= starve + 1'b1;
            end
            svc_valid <= 1'b0;
            svc_host  <= 1'b0;
            svc_chan  <= '0;
            state     <= IDLE;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gps_srq_sched.sv
// Self-checking bench for gps_srq_sched: directed scenarios plus random traffic.
// A behavioural model predicts every output each cycle; literal checks pin key cases.
// Ack timeout shortened to 16 cycles to keep runs short.
module tb_gps_srq_sched;
  import gps_srq_sched_pkg::*;

  localparam int N  = GPS_CHANS;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   chan_srq;
  logic           host_srq;
  logic [N-1:0]   chan_mask;
  logic           svc_ack;
  logic           svc_valid;
  logic           svc_host;
  logic [3:0]     svc_chan;
  logic [N-1:0]   pending;
  logic           timeout_flag;
  logic [3:0]     ovr_sel;
  logic [3:0]     ovr_cnt;
  logic           ovr_clr;

  always #5 clk = ~clk;

  gps_srq_sched #(.ACK_TIMEOUT_CYC(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .chan_srq     (chan_srq),
    .host_srq     (host_srq),
    .chan_mask    (chan_mask),
    .svc_ack      (svc_ack),
    .svc_valid    (svc_valid),
    .svc_host     (svc_host),
    .svc_chan     (svc_chan),
    .pending      (pending),
    .timeout_flag (timeout_flag),
    .ovr_sel      (ovr_sel),
    .ovr_cnt      (ovr_cnt),
    .ovr_clr      (ovr_clr)
  );

  int checks   = 0;
  int failures = 0;

  // stimulus for the current cycle
  logic [N-1:0] d_srq  = '0;
  logic [N-1:0] d_mask = '1;
  logic         d_host = 1'b0;
  logic         d_ack  = 1'b0;
  logic         d_clr  = 1'b0;
  logic         d_rst  = 1'b1;
  logic [3:0]   d_sel  = '0;

  // behavioural model state
  logic [N-1:0] m_pend;
  int           m_ovr [N];
  bit           m_valid, m_host, m_tflag, decide_next;
  int           m_chan, m_age, m_rr, m_starve;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend = '0;
    for (int i = 0; i < N; i++) m_ovr[i] = 0;
    m_valid = 0; m_host = 0; m_chan = 0; m_age = 0;
    m_rr = N - 1; m_starve = 0; m_tflag = 0; decide_next = 0;
  endtask

  task automatic start_grant(input bit h, input int ch);
    m_valid = 1; m_host = h; m_chan = ch; m_age = 0;
  endtask

  task automatic end_grant();
    m_valid = 0; m_host = 0; m_chan = 0;
  endtask

  // advance the model across one clock edge using this cycle's stimulus
  task automatic model_step();
    int ack_ch;
    bit drop, tmo;
    logic [N-1:0] eff;
    if (d_rst) begin
      model_reset();
      return;
    end
    ack_ch = (m_valid && d_ack && !m_host) ? m_chan : -1;
    drop   = m_valid && !m_host && !d_mask[m_chan];
    tmo    = m_valid && !d_ack && !drop && (m_age == TO - 1);
    if (d_clr) m_tflag = 0;
    else if (tmo) m_tflag = 1;

    if (m_valid) begin
      if (d_ack) begin
        if (m_host) m_starve = 0;
        else begin
          m_rr = m_chan;
          if (d_host && m_starve < HOST_MAX) m_starve++;
        end
        end_grant();
      end else if (drop || tmo) begin
        if (!m_host) m_rr = m_chan;
        end_grant();
      end else begin
        m_age++;
      end
    end else if (decide_next) begin
      decide_next = 0;
      eff = m_pend & d_mask;
      if (d_host && (eff == '0 || m_starve >= HOST_MAX)) start_grant(1, 0);
      else begin
        for (int k = 1; k <= N; k++) begin
          if (eff[(m_rr + k) % N]) begin
            start_grant(0, (m_rr + k) % N);
            break;
          end
        end
      end
    end else if (m_pend != '0 || d_host) begin
      decide_next = 1;
    end

    for (int i = 0; i < N; i++) begin
      if (d_clr) m_ovr[i] = 0;
      else if (d_srq[i] && d_mask[i] && m_pend[i] && ack_ch != i && m_ovr[i] < 15) m_ovr[i]++;
      if (!d_mask[i]) m_pend[i] = 1'b0;
      else if (d_srq[i]) m_pend[i] = 1'b1;
      else if (ack_ch == i) m_pend[i] = 1'b0;
    end
  endtask

  task automatic compare_all();
    chk("svc_valid", svc_valid, m_valid);
    chk("svc_host", svc_host, m_host);
    chk("svc_chan", svc_chan, m_chan);
    chk("pending", pending, m_pend);
    chk("timeout_flag", timeout_flag, m_tflag);
    chk("ovr_cnt", ovr_cnt, (d_sel < N) ? m_ovr[d_sel] : 0);
  endtask

  // drive one cycle, compare against model, step the model, land at posedge+1
  task automatic tick();
    chan_srq = d_srq; host_srq = d_host; chan_mask = d_mask;
    svc_ack = d_ack; ovr_sel = d_sel; ovr_clr = d_clr; rst = d_rst;
    #1;
    compare_all();
    model_step();
    @(posedge clk);
    #1;
    d_srq = '0; d_ack = 1'b0; d_clr = 1'b0;
  endtask

  task automatic wait_grant(input logic [N-1:0] srq, output int ch, output bit h);
    int n = 0;
    while (svc_valid !== 1'b1 && n < 200) begin
      d_srq = srq;
      tick();
      n++;
    end
    chk("grant_wait", svc_valid, 1);
    ch = svc_chan;
    h  = svc_host;
  endtask

  task automatic do_reset();
    d_rst = 1'b1; tick(); d_rst = 1'b0;
  endtask

  int ch;
  bit h;
  int hosts[$];
  int n;

  initial begin
    chan_srq = '0; host_srq = 0; chan_mask = '1; svc_ack = 0;
    ovr_sel = '0; ovr_clr = 0; rst = 1'b1;
    @(posedge clk); #1;
    model_reset();
    tick();
    d_rst = 1'b0;
    chk("rst_valid", svc_valid, 0);
    chk("rst_pending", pending, 0);
    chk("rst_tflag", timeout_flag, 0);
    tick(); tick();

    // single pulse on ch3: pending next cycle, grant 3 cycles after pulse
    d_srq = 12'h008; tick();
    chk("s1_pend", pending, 12'h008);
    chk("s1_valid_c1", svc_valid, 0);
    tick();
    chk("s1_valid_c2", svc_valid, 0);
    tick();
    chk("s1_valid_c3", svc_valid, 1);
    chk("s1_chan", svc_chan, 3);
    tick(); tick();
    d_ack = 1'b1; tick();
    chk("s1_valid_after_ack", svc_valid, 0);
    chk("s1_pend_after_ack", pending, 0);

    // round-robin order from reset pointer, then wrap with rr=3
    do_reset();
    d_srq = 12'h824; tick();
    wait_grant('0, ch, h); chk("rr_g0", ch, 2); d_ack = 1'b1; tick();
    wait_grant('0, ch, h); chk("rr_g1", ch, 5); d_ack = 1'b1; tick();
    wait_grant('0, ch, h); chk("rr_g2", ch, 11); d_ack = 1'b1; tick();
    d_srq = 12'h008; tick();
    wait_grant('0, ch, h); chk("rr_set3", ch, 3); d_ack = 1'b1; tick();
    d_srq = 12'h024; tick();
    wait_grant('0, ch, h); chk("rr_wrap0", ch, 5); d_ack = 1'b1; tick();
    wait_grant('0, ch, h); chk("rr_wrap1", ch, 2); d_ack = 1'b1; tick();

    // host starvation guard: host after every 8 channel acks
    do_reset();
    d_host = 1'b1;
    for (int g = 0; g < 18; g++) begin
      wait_grant('1, ch, h);
      if (h) hosts.push_back(g);
      d_srq = '1; d_ack = 1'b1; tick();
    end
    d_host = 1'b0;
    chk("host_count", hosts.size(), 2);
    if (hosts.size() >= 2) begin
      chk("host_first", hosts[0], 8);
      chk("host_second", hosts[1], 17);
    end

    // overrun counting, saturation, out-of-range select, clear
    do_reset();
    d_sel = 4'd7;
    d_srq = 12'h080; tick();
    tick();
    d_srq = 12'h080; tick();
    d_srq = 12'h080; tick();
    chk("ovr_2", ovr_cnt, 2);
    for (int i = 0; i < 20; i++) begin
      d_srq = 12'h080; tick();
    end
    chk("ovr_sat", ovr_cnt, 15);
    d_sel = 4'd12; tick();
    chk("ovr_sel_oob", ovr_cnt, 0);
    d_sel = 4'd7; d_clr = 1'b1; tick();
    chk("ovr_clr", ovr_cnt, 0);

    // ack timeout: grant 4 abandoned after 16 cycles, then ch5 served
    do_reset();
    d_srq = 12'h008; tick();
    wait_grant('0, ch, h); chk("to_set3", ch, 3); d_ack = 1'b1; tick();
    d_srq = 12'h030; tick();
    wait_grant('0, ch, h); chk("to_grant4", ch, 4);
    n = 1;
    while (svc_valid === 1'b1 && n < 40) begin
      tick();
      if (svc_valid === 1'b1) n++;
    end
    chk("to_cycles", n, TO);
    chk("to_flag", timeout_flag, 1);
    chk("to_pend4", pending[4], 1);
    wait_grant('0, ch, h); chk("to_next5", ch, 5);
    d_ack = 1'b1; tick();

    // mask-off withdraws the grant; reset mid-grant clears everything
    do_reset();
    d_srq = 12'h200; tick();
    wait_grant('0, ch, h); chk("mask_grant9", ch, 9);
    d_mask = ~12'h200; tick();
    chk("mask_valid", svc_valid, 0);
    chk("mask_pend9", pending[9], 0);
    d_mask = '1;
    d_srq = '1; tick();
    wait_grant('0, ch, h);
    chk("rst_g_pend", pending, 12'hFFF);
    d_rst = 1'b1; tick(); d_rst = 1'b0;
    chk("rst_g_valid", svc_valid, 0);
    chk("rst_g_host", svc_host, 0);
    chk("rst_g_chan", svc_chan, 0);
    chk("rst_g_pend0", pending, 0);

    // random traffic against the model
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N; i++) d_srq[i] = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 19) == 0) d_host = ~d_host;
      if ($urandom_range(0, 49) == 0) d_mask[$urandom_range(0, N - 1)] = 1'b0;
      else if ($urandom_range(0, 29) == 0) d_mask = '1;
      d_ack = (svc_valid === 1'b1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
      d_sel = 4'($urandom_range(0, 15));
      d_clr = ($urandom_range(0, 99) == 0);
      d_rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    d_rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
